// File: rtl/rcc_pkg.sv
// Shared RCC definitions for the VSW-domain LSE start-up / clock-security logic.
package rcc_pkg;

    localparam int RCC_LSE_STARTUP_CYC = 64;
    localparam int RCC_LSE_CSS_TIMEOUT = 16;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        FAIL  = 2'd3
    } lse_css_state_e;

endpackage

// File: rtl/rcc_sync_cell.sv
// Multi-stage synchronizer into lsi_clk with an edge pulse from its last two stages.
module rcc_sync_cell #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_sync,
    output logic o_edge
);

    logic [STAGES-1:0] r_q;

    // Shift the asynchronous input through the synchronizer chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else begin
            r_q <= {r_q[STAGES-2:0], i_d};
        end
    end

    assign o_sync = r_q[STAGES-1];
    assign o_edge = r_q[STAGES-1] ^ r_q[STAGES-2];

endmodule

// File: rtl/rcc_lse_css_ctrl.sv
// LSE start-up sequencer and LSI-timed clock-security watchdog.
// Drives LSE ready, sticky CSS fail, clock-gate enable and the CSS interrupt pulse.
import rcc_pkg::*;

module rcc_lse_css_ctrl #(
    parameter int STARTUP_CYC = RCC_LSE_STARTUP_CYC,
    parameter int TIMEOUT_CYC = RCC_LSE_CSS_TIMEOUT
) (
    input  logic       lsi_clk,
    input  logic       pwr_vsw_rst,
    input  logic       lseon,
    input  logic       lsecsson,
    input  logic       lse_rdy_raw,
    input  logic       lse_div_tgl,
    output logic       lserdy,
    output logic       lsecss_fail,
    output logic       lse_gate_en,
    output logic       css_irq,
    output logic [1:0] state
);

    localparam int SW = $clog2(STARTUP_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SW-1:0] STAB_LAST = SW'(STARTUP_CYC - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(STARTUP_CYC);
    localparam logic [WW-1:0] WDG_LAST  = WW'(TIMEOUT_CYC - 1);
    localparam logic [WW-1:0] WDG_MAX   = WW'(TIMEOUT_CYC);

    lse_css_state_e r_state;
    lse_css_state_e w_state_nxt;
    logic [SW-1:0]  r_stab_cnt;
    logic [SW-1:0]  w_stab_nxt;
    logic [SW-1:0]  w_stab_inc;
    logic [WW-1:0]  r_wdg_cnt;
    logic [WW-1:0]  w_wdg_nxt;
    logic [WW-1:0]  w_wdg_inc;
    logic           w_rdy_s;
    logic           w_act;
    logic           w_timeout;
    logic           r_lserdy;
    logic           r_lsecss_fail;
    logic           r_lse_gate_en;
    logic           r_css_irq;

    rcc_sync_cell #(.STAGES(2)) u_rdy_sync (
        .i_clk  (lsi_clk),
        .i_rst  (pwr_vsw_rst),
        .i_d    (lse_rdy_raw),
        .o_sync (w_rdy_s),
        .o_edge ()
    );

    rcc_sync_cell #(.STAGES(3)) u_tgl_sync (
        .i_clk  (lsi_clk),
        .i_rst  (pwr_vsw_rst),
        .i_d    (lse_div_tgl),
        .o_sync (),
        .o_edge (w_act)
    );

    assign w_stab_inc = (r_stab_cnt == STAB_MAX) ? r_stab_cnt : r_stab_cnt + SW'(1);
    assign w_wdg_inc  = (r_wdg_cnt == WDG_MAX) ? r_wdg_cnt : r_wdg_cnt + WW'(1);
    // An activity pulse on the limit cycle rescues the watchdog.
    assign w_timeout  = lsecsson && !w_act && (r_wdg_cnt == WDG_LAST);

    // Next-state and counter update; lseon low overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab_cnt;
        w_wdg_nxt   = r_wdg_cnt;
        if (!lseon) begin
            w_state_nxt = OFF;
            w_stab_nxt  = '0;
            w_wdg_nxt   = '0;
        end else begin
            case (r_state)
                OFF: begin
                    w_state_nxt = START;
                    w_stab_nxt  = '0;
                    w_wdg_nxt   = '0;
                end
                START: begin
                    w_wdg_nxt = '0;
                    if (!w_rdy_s) begin
                        w_stab_nxt = '0;
                    end else if (r_stab_cnt == STAB_LAST) begin
                        w_state_nxt = RUN;
                        w_stab_nxt  = '0;
                    end else begin
                        w_stab_nxt = w_stab_inc;
                    end
                end
                RUN: begin
                    w_stab_nxt = '0;
                    if (w_timeout) begin
                        w_state_nxt = FAIL;
                    end else if (!w_rdy_s) begin
                        w_state_nxt = START;
                        w_wdg_nxt   = '0;
                    end else if (!lsecsson || w_act) begin
                        w_wdg_nxt = '0;
                    end else begin
                        w_wdg_nxt = w_wdg_inc;
                    end
                end
                FAIL: begin
                    w_state_nxt = FAIL;
                end
                default: begin
                    w_state_nxt = OFF;
                    w_stab_nxt  = '0;
                    w_wdg_nxt   = '0;
                end
            endcase
        end
    end

    // State, counters and outputs registered together so outputs track the state
    always_ff @(posedge lsi_clk or posedge pwr_vsw_rst) begin
        if (pwr_vsw_rst) begin
            r_state       <= OFF;
            r_stab_cnt    <= '0;
            r_wdg_cnt     <= '0;
            r_lserdy      <= 1'b0;
            r_lsecss_fail <= 1'b0;
            r_lse_gate_en <= 1'b0;
            r_css_irq     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_stab_cnt    <= w_stab_nxt;
            r_wdg_cnt     <= w_wdg_nxt;
            r_lserdy      <= (w_state_nxt == RUN);
            r_lse_gate_en <= (w_state_nxt == RUN);
            r_lsecss_fail <= (w_state_nxt == FAIL);
            r_css_irq     <= (w_state_nxt == FAIL) && (r_state != FAIL);
        end
    end

    assign lserdy      = r_lserdy;
    assign lsecss_fail = r_lsecss_fail;
    assign lse_gate_en = r_lse_gate_en;
    assign css_irq     = r_css_irq;
    assign state       = r_state;

endmodule

// File: tb/tb_rcc_lse_css_ctrl.sv
// Directed, table-driven bench for rcc_lse_css_ctrl with default parameters (64 / 16).
module tb_rcc_lse_css_ctrl;

    logic       lsi_clk = 1'b0;
    logic       pwr_vsw_rst;
    logic       lseon;
    logic       lsecsson;
    logic       lse_rdy_raw;
    logic       lse_div_tgl;
    logic       lserdy;
    logic       lsecss_fail;
    logic       lse_gate_en;
    logic       css_irq;
    logic [1:0] state;

    always #5 lsi_clk = ~lsi_clk;

    rcc_lse_css_ctrl dut (
        .lsi_clk     (lsi_clk),
        .pwr_vsw_rst (pwr_vsw_rst),
        .lseon       (lseon),
        .lsecsson    (lsecsson),
        .lse_rdy_raw (lse_rdy_raw),
        .lse_div_tgl (lse_div_tgl),
        .lserdy      (lserdy),
        .lsecss_fail (lsecss_fail),
        .lse_gate_en (lse_gate_en),
        .css_irq     (css_irq),
        .state       (state)
    );

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    // Output pattern {lserdy, lsecss_fail, lse_gate_en, css_irq}
    localparam logic [3:0] O_IDLE  = 4'b0000;
    localparam logic [3:0] O_RUN   = 4'b1010;
    localparam logic [3:0] O_FIRQ  = 4'b0101;
    localparam logic [3:0] O_FAIL  = 4'b0100;

    typedef struct {
        string      name;
        logic       on;
        logic       css;
        logic       raw;
        logic       tgl;
        int         n;
        logic [1:0] st;
        logic [3:0] outs;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(string nm, logic i_on, logic i_css, logic i_raw, logic i_tgl,
                                int n, logic [1:0] st, logic [3:0] o);
        vec_t v;
        v.name = nm; v.on = i_on; v.css = i_css; v.raw = i_raw; v.tgl = i_tgl;
        v.n = n; v.st = st; v.outs = o;
        vecs.push_back(v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge lsi_clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] exp_st, input logic [3:0] exp_o);
        logic [3:0] act_o;
        act_o = {lserdy, lsecss_fail, lse_gate_en, css_irq};
        total++;
        if (state !== exp_st || act_o !== exp_o) begin
            bad++;
            $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     nm, state, act_o, exp_st, exp_o);
        end
    endtask

    initial begin
        // Start-up with ready already asserted: START after edge 1, rdy_s high
        // from edge 2, 64 qualifying cycles end at edge 66 -> RUN.
        add("start_enter",   1'b1, 1'b0, 1'b1, 1'b0, 1,  S_START, O_IDLE);
        add("start_hold65",  1'b1, 1'b0, 1'b1, 1'b0, 64, S_START, O_IDLE);
        add("start_ready66", 1'b1, 1'b0, 1'b1, 1'b0, 1,  S_RUN,   O_RUN);
        // Ready glitch at count 40: rdy_s low sampled at edge 44, RUN at edge 108.
        add("off_again",     1'b0, 1'b0, 1'b1, 1'b0, 1,  S_OFF,   O_IDLE);
        add("glitch_pre",    1'b1, 1'b0, 1'b1, 1'b0, 41, S_START, O_IDLE);
        add("glitch_low",    1'b1, 1'b0, 1'b0, 1'b0, 1,  S_START, O_IDLE);
        add("glitch_wait",   1'b1, 1'b0, 1'b1, 1'b0, 65, S_START, O_IDLE);
        add("glitch_ready",  1'b1, 1'b0, 1'b1, 1'b0, 1,  S_RUN,   O_RUN);
        // Watchdog fed by a toggle every 4 cycles, then starved.
        add("wdg_fed_a",     1'b1, 1'b1, 1'b1, 1'b1, 4,  S_RUN,   O_RUN);
        add("wdg_fed_b",     1'b1, 1'b1, 1'b1, 1'b0, 4,  S_RUN,   O_RUN);
        add("wdg_fed_c",     1'b1, 1'b1, 1'b1, 1'b1, 4,  S_RUN,   O_RUN);
        add("wdg_fed_d",     1'b1, 1'b1, 1'b1, 1'b0, 4,  S_RUN,   O_RUN);
        add("wdg_fed_e",     1'b1, 1'b1, 1'b1, 1'b1, 4,  S_RUN,   O_RUN);
        add("wdg_starve",    1'b1, 1'b1, 1'b1, 1'b1, 14, S_RUN,   O_RUN);
        add("css_fail_irq",  1'b1, 1'b1, 1'b1, 1'b1, 1,  S_FAIL,  O_FIRQ);
        add("css_sticky",    1'b1, 1'b1, 1'b1, 1'b1, 1,  S_FAIL,  O_FAIL);
        add("fail_ignores",  1'b1, 1'b0, 1'b0, 1'b1, 5,  S_FAIL,  O_FAIL);
        add("fail_exit_off", 1'b0, 1'b0, 1'b0, 1'b1, 1,  S_OFF,   O_IDLE);
        // act on the watchdog limit cycle (edge 16) rescues; timeout at edge 32
        // coincides with rdy_s falling, and FAIL wins.
        add("act_start",     1'b1, 1'b0, 1'b1, 1'b1, 1,  S_START, O_IDLE);
        add("act_hold",      1'b1, 1'b0, 1'b1, 1'b1, 64, S_START, O_IDLE);
        add("act_run",       1'b1, 1'b0, 1'b1, 1'b1, 1,  S_RUN,   O_RUN);
        add("act_wdg13",     1'b1, 1'b1, 1'b1, 1'b1, 13, S_RUN,   O_RUN);
        add("act_on_limit",  1'b1, 1'b1, 1'b1, 1'b0, 3,  S_RUN,   O_RUN);
        add("act_after",     1'b1, 1'b1, 1'b1, 1'b0, 13, S_RUN,   O_RUN);
        add("rdy_drop",      1'b1, 1'b1, 1'b0, 1'b0, 2,  S_RUN,   O_RUN);
        add("rdy_vs_tmo",    1'b1, 1'b1, 1'b0, 1'b0, 1,  S_FAIL,  O_FIRQ);
        add("fail_off2",     1'b0, 1'b0, 1'b0, 1'b0, 1,  S_OFF,   O_IDLE);
        // lseon falls on the timeout cycle: OFF, no interrupt.
        add("lo_start",      1'b1, 1'b0, 1'b1, 1'b0, 1,  S_START, O_IDLE);
        add("lo_hold",       1'b1, 1'b0, 1'b1, 1'b0, 64, S_START, O_IDLE);
        add("lo_run",        1'b1, 1'b0, 1'b1, 1'b0, 1,  S_RUN,   O_RUN);
        add("lo_wdg15",      1'b1, 1'b1, 1'b1, 1'b0, 15, S_RUN,   O_RUN);
        add("lseon_vs_tmo",  1'b0, 1'b1, 1'b1, 1'b0, 1,  S_OFF,   O_IDLE);
        add("lo_no_irq",     1'b0, 1'b1, 1'b1, 1'b0, 1,  S_OFF,   O_IDLE);

        pwr_vsw_rst = 1'b1;
        lseon       = 1'b0;
        lsecsson    = 1'b0;
        lse_rdy_raw = 1'b0;
        lse_div_tgl = 1'b0;
        tick(2);
        check("reset_state", S_OFF, O_IDLE);
        pwr_vsw_rst = 1'b0;
        tick(1);
        check("idle_after_reset", S_OFF, O_IDLE);

        foreach (vecs[i]) begin
            lseon       = vecs[i].on;
            lsecsson    = vecs[i].css;
            lse_rdy_raw = vecs[i].raw;
            lse_div_tgl = vecs[i].tgl;
            tick(vecs[i].n);
            check(vecs[i].name, vecs[i].st, vecs[i].outs);
        end

        // Reset pulse during RUN: outputs clear without waiting for a clock edge.
        lseon       = 1'b1;
        lsecsson    = 1'b0;
        lse_rdy_raw = 1'b1;
        tick(70);
        check("rst_pre_run", S_RUN, O_RUN);
        @(posedge lsi_clk);
        #3;
        pwr_vsw_rst = 1'b1;
        #1;
        check("rst_async_clear", S_OFF, O_IDLE);
        tick(2);
        pwr_vsw_rst = 1'b0;
        // Synchronizers restart from 0, so the full 66-edge start-up applies.
        tick(1);
        check("rst_restart", S_START, O_IDLE);
        tick(64);
        check("rst_full_count65", S_START, O_IDLE);
        tick(1);
        check("rst_ready66", S_RUN, O_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rcc_lse_css_ctrl.md
# rcc_lse_css_ctrl

LSE start-up and clock-security sequencer for the VSW (backup) domain. It runs on `lsi_clk` and turns the register bits `lseon` and `lsecsson` into the LSE ready, CSS-fail and clock-gate-enable signals. It also supervises LSE activity with an LSI-timed watchdog. It sits between `rcc_vsw_reg` and the LSE clock gate / RTC clock switch.

## Interface
Parameters:
- `STARTUP_CYC`, default 64: consecutive LSI cycles that the synchronized LSE ready must stay high before the LSE is declared ready. Legal range ≥1.
- `TIMEOUT_CYC`, default 16: LSI cycles without an LSE activity edge that trigger CSS failure. Legal range ≥2.

Ports:
- `lsi_clk` in 1: the only clock.
- `pwr_vsw_rst` in 1: reset, asynchronous, active-high.
- `lseon` in 1: LSE enable, from the register.
- `lsecsson` in 1: CSS enable, from the register.
- `lse_rdy_raw` in 1: analog oscillator ready. Asynchronous.
- `lse_div_tgl` in 1: produced in the LSE domain; toggles once every 4 LSE cycles. Asynchronous.
- `lserdy` out 1: LSE ready status.
- `lsecss_fail` out 1: sticky CSS failure flag.
- `lse_gate_en` out 1: enable for the LSE clock gate.
- `css_irq` out 1: one-cycle pulse on entry to FAIL.
- `state` out 2: current FSM state, for debug and status.

## Operation
- Synchronizers:
  - `lse_rdy_raw` passes through 2 flops to give `rdy_s`.
  - `lse_div_tgl` passes through 3 flops. `act = s[2]^s[1]`, a one-cycle activity pulse.
- States (encoding):
  - OFF=0
  - START=1
  - RUN=2
  - FAIL=3
- Reset: state OFF. Both counters 0. All outputs 0.
- OFF:
  - Counters held at 0.
  - `lseon`=1 → START.
- START:
  - `stab_cnt` increments on each cycle with `rdy_s`=1. It clears to 0 on any cycle with `rdy_s`=0.
  - When `stab_cnt`==`STARTUP_CYC`-1 and `rdy_s`=1 → RUN.
- RUN:
  - `lserdy`=1 and `lse_gate_en`=1.
  - With `lsecsson`=1:
    - `wdg_cnt` clears on `act`, otherwise increments.
    - When `wdg_cnt`==`TIMEOUT_CYC`-1 and `act`=0 → FAIL.
  - With `lsecsson`=0, `wdg_cnt` is held at 0.
  - `rdy_s`=0 → START, with `stab_cnt` cleared.
- FAIL:
  - `lsecss_fail`=1; `lserdy`=0; `lse_gate_en`=0.
  - `lsecsson` and `rdy_s` are ignored.
  - The only exit is `lseon`=0 → OFF.
- Priority, applied in every state: `lseon`=0 → OFF, which overrides every other transition and clears both counters.
- Counters:
  - Widths are `$clog2(STARTUP_CYC+1)` and `$clog2(TIMEOUT_CYC+1)`.
  - Both saturate; they never wrap.
- `wdg_cnt` also clears on the RUN-entry cycle.

## Timing
- Outputs are decoded from the registered state. They change in the cycle after the transition condition is sampled.
- Latencies:
  - `lse_rdy_raw` rise to `lserdy`=1: 2 (sync) + `STARTUP_CYC` + 1 cycles minimum.
  - `lse_div_tgl` edge to `act` pulse: 3 cycles.
  - Last `act` to `lsecss_fail`=1: `TIMEOUT_CYC` cycles.
- `css_irq`:
  - High exactly in the first cycle in which `state`==FAIL.
  - Not re-issued while FAIL persists.
- Simultaneous events:
  - `act` in the same cycle as the timeout limit: `act` wins, no FAIL.
  - `lseon` fall in the same cycle as the timeout: → OFF, no `css_irq`.
  - `rdy_s` fall in the same cycle as the timeout: FAIL wins.
- Reset asserted mid-operation:
  - All outputs drop to 0 asynchronously.
  - Synchronizer flops reset to 0.

## Structure
- Shared package `rcc_pkg`:
  - `lse_css_state_e` enum (OFF/START/RUN/FAIL).
  - Default constants `RCC_LSE_STARTUP_CYC`=64 and `RCC_LSE_CSS_TIMEOUT`=16.
- Sub-module `rcc_sync_cell`:
  - Parameterized stage count, async active-high reset to 0.
  - Instantiated twice: 2 stages for ready, 3 stages for toggle.
  - Edge detect XORs the last two stages.
- The FSM and both counters live in the top module.

## Test plan
- Reset, then `lseon`=1 with `lse_rdy_raw`=1 held and `STARTUP_CYC`=64 → `state` OFF→START, and `lserdy`=1 at cycle 67 after `lse_rdy_raw` rise.
- In START, `lse_rdy_raw` glitches low 1 cycle at count 40 → `stab_cnt` restarts; `lserdy` is delayed by a further 41+ cycles.
- RUN with `lsecsson`=1, toggle every 4 cycles, then toggle stops → `lsecss_fail`=1 and `css_irq` pulses once 16 cycles after the last `act`; `lse_gate_en`=0.
- In FAIL, set `lsecsson`=0 → stays FAIL. Then `lseon`=0 → OFF, all outputs 0.
- `act` arrives exactly on cycle 15 of the watchdog → no FAIL, `wdg_cnt`=0 next cycle.
- `pwr_vsw_rst` pulsed during RUN → outputs 0 immediately; after release, START is re-entered only via `lseon` plus the full start-up count.
